// File: rtl/z80_bus_responder_if.sv
// ---------------------------------------------------------------------------
// z80_bus_responder_if
//   Z80 CPU memory/IO bus as seen between a CPU (master) and a bus target
//   (slave).
//   A        : CPU address
//   cpu_dout : CPU write data
//   di       : read data returned to the CPU
//   mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n : CPU bus strobes, active low
//   wait_n   : wait request from the target, active low
// ---------------------------------------------------------------------------
interface z80_bus_responder_if;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic [7:0]  di;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfsh_n;
  logic        wait_n;

  modport master (
    output A, cpu_dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
    input  di, wait_n
  );

  modport slave (
    input  A, cpu_dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
    output di, wait_n
  );
endinterface

// File: rtl/z80_bus_responder.sv
// ---------------------------------------------------------------------------
// z80_bus_responder
//   Bus target for the tv80s core. Decodes memory, IO and interrupt
//   acknowledge cycles, serves them from an internal 64 KiB byte RAM and
//   optionally stretches them with wait states. IO port p maps onto RAM
//   address {IO_PAGE, p}. A side-band load port writes RAM in any state.
//
//   Build option: define Z80_BUS_RESPONDER_WAIT_EN to enable wait-state
//   generation. Without it the WAIT state does not exist, wait_n is tied
//   high and MEM_WAIT / IO_WAIT / M1_WAIT have no effect.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : synchronous reset, active low
//   bus        : CPU bus (slave modport of z80_bus_responder_if)
//   busy       : high whenever the FSM is not idle
//   io_wr_stb  : one-cycle pulse when an IO write commits
//   io_wr_addr : port number of the last IO write
//   io_wr_data : data of the last IO write
//   ld_en      : side-band RAM write enable
//   ld_addr    : side-band write address
//   ld_data    : side-band write data
//   ld_err     : one-cycle pulse when a side-band write lost to a CPU write
// ---------------------------------------------------------------------------
module z80_bus_responder #(
  parameter int unsigned MEM_WAIT   = 0,
  parameter int unsigned IO_WAIT    = 1,
  parameter int unsigned M1_WAIT    = 0,
  parameter logic [7:0]  IO_PAGE    = 8'h10,
  parameter logic [7:0]  INTACK_VEC = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  z80_bus_responder_if.slave        bus,
  output logic                      busy,
  output logic                      io_wr_stb,
  output logic [7:0]                io_wr_addr,
  output logic [7:0]                io_wr_data,
  input  logic                      ld_en,
  input  logic [15:0]               ld_addr,
  input  logic [7:0]                ld_data,
  output logic                      ld_err
);

`ifdef Z80_BUS_RESPONDER_WAIT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_HOLD = 2'd2, ST_WAIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_HOLD = 2'd2} state_t;
`endif

  typedef enum logic [1:0] {K_MEM = 2'd0, K_IO = 2'd1, K_INTACK = 2'd2} kind_t;

  // Wait counts are clamped so they always fit the 5-bit counter.
  function automatic logic [4:0] sat30(input int unsigned n);
    return (n > 30) ? 5'd30 : n[4:0];
  endfunction

  localparam logic [4:0] MEM_N    = sat30(MEM_WAIT);
  localparam logic [4:0] MEM_M1_N = sat30(MEM_WAIT + M1_WAIT);
  localparam logic [4:0] IO_N     = sat30(IO_WAIT);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic        io_wr_stb_q, io_wr_stb_d;
  logic [7:0]  io_wr_addr_q, io_wr_addr_d;
  logic [7:0]  io_wr_data_q, io_wr_data_d;
  logic        ld_err_q, ld_err_d;
  logic [7:0]  di_q;

  logic [7:0]  mem [0:65535];

  // Start decode
  logic        start;
  kind_t       start_kind;
  logic [4:0]  req_wait;
  logic        hold_done;
  logic        cpu_wr_commit;
  logic        rd_commit;

  always_comb begin
    start      = 1'b0;
    start_kind = K_MEM;
    req_wait   = 5'd0;
    // Refresh cycles never qualify as memory accesses.
    if (!bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n)) begin
      start      = 1'b1;
      start_kind = K_MEM;
      req_wait   = bus.m1_n ? MEM_N : MEM_M1_N;
    end else if (!bus.iorq_n && !bus.m1_n) begin
      start      = 1'b1;
      start_kind = K_INTACK;
    end else if (!bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n)) begin
      start      = 1'b1;
      start_kind = K_IO;
      req_wait   = IO_N;
    end
  end

  // An interrupt acknowledge never drives rd_n/wr_n, so it may only be
  // released by iorq_n; otherwise the same cycle would be seen again in IDLE.
  assign hold_done = ((kind_q == K_MEM) ? bus.mreq_n : bus.iorq_n) ||
                     ((kind_q != K_INTACK) && bus.rd_n && bus.wr_n);

  // A write landing on a reset edge is abandoned.
  assign cpu_wr_commit = (state_q == ST_ACCESS) && wr_q && reset_n;
  assign rd_commit     = (state_q == ST_ACCESS) && !wr_q;

`ifdef Z80_BUS_RESPONDER_WAIT_EN
  logic [4:0] cnt_q, cnt_d;
  logic       wait_n_q, wait_n_d;
`else
  logic [4:0] unused_req_wait;
  assign unused_req_wait = req_wait;
`endif

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    io_wr_stb_d  = 1'b0;
    io_wr_addr_d = io_wr_addr_q;
    io_wr_data_d = io_wr_data_q;
    ld_err_d     = ld_en && cpu_wr_commit;
`ifdef Z80_BUS_RESPONDER_WAIT_EN
    cnt_d        = cnt_q;
    wait_n_d     = wait_n_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          kind_d = start_kind;
          // rd_n and wr_n both low resolves to a read.
          wr_d   = (start_kind != K_INTACK) && !bus.wr_n && bus.rd_n;
          addr_d = (start_kind == K_IO) ? {IO_PAGE, bus.A[7:0]} : bus.A;
`ifdef Z80_BUS_RESPONDER_WAIT_EN
          cnt_d  = req_wait;
          if (req_wait != 5'd0) begin
            state_d  = ST_WAIT;
            wait_n_d = 1'b0;
          end else begin
            state_d  = ST_ACCESS;
          end
`else
          state_d = ST_ACCESS;
`endif
        end
      end
`ifdef Z80_BUS_RESPONDER_WAIT_EN
      ST_WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d  = ST_ACCESS;
          wait_n_d = 1'b1;
        end
      end
`endif
      ST_ACCESS: begin
        if (wr_q && (kind_q == K_IO)) begin
          io_wr_stb_d  = 1'b1;
          io_wr_addr_d = addr_q[7:0];
          io_wr_data_d = bus.cpu_dout;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      kind_q       <= K_MEM;
      wr_q         <= 1'b0;
      addr_q       <= 16'h0000;
      io_wr_stb_q  <= 1'b0;
      io_wr_addr_q <= 8'h00;
      io_wr_data_q <= 8'h00;
      ld_err_q     <= 1'b0;
`ifdef Z80_BUS_RESPONDER_WAIT_EN
      cnt_q        <= 5'd0;
      wait_n_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      io_wr_stb_q  <= io_wr_stb_d;
      io_wr_addr_q <= io_wr_addr_d;
      io_wr_data_q <= io_wr_data_d;
      ld_err_q     <= ld_err_d;
`ifdef Z80_BUS_RESPONDER_WAIT_EN
      cnt_q        <= cnt_d;
      wait_n_q     <= wait_n_d;
`endif
    end
  end

  // Single RAM write port: a CPU write commit takes it, a coincident
  // side-band write is dropped and flagged through ld_err.
  always_ff @(posedge clk) begin
    if (cpu_wr_commit) begin
      mem[addr_q] <= bus.cpu_dout;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // RAM read register doubles as the CPU read-data register; it reads the
  // pre-write contents when the load port hits the same address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      di_q <= 8'hFF;
    end else if (rd_commit) begin
      di_q <= (kind_q == K_INTACK) ? INTACK_VEC : mem[addr_q];
    end
  end

  assign bus.di     = di_q;
`ifdef Z80_BUS_RESPONDER_WAIT_EN
  assign bus.wait_n = wait_n_q;
`else
  assign bus.wait_n = 1'b1;
`endif
  assign busy       = (state_q != ST_IDLE);
  assign io_wr_stb  = io_wr_stb_q;
  assign io_wr_addr = io_wr_addr_q;
  assign io_wr_data = io_wr_data_q;
  assign ld_err     = ld_err_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_z80_bus_responder
//   Randomised bench for z80_bus_responder. A driver acts as the Z80 and
//   pushes expected results into queues; a monitor on the falling edge pops
//   and compares whenever the DUT finishes a bus cycle, pulses io_wr_stb or
//   pulses ld_err.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_z80_bus_responder;
  localparam int         MEM_WAIT   = 2;
  localparam int         IO_WAIT    = 1;
  localparam int         M1_WAIT    = 1;
  localparam logic [7:0] IO_PAGE    = 8'h10;
  localparam logic [7:0] INTACK_VEC = 8'hFF;
  localparam int K_MEM = 0, K_IO = 1, K_INT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy, io_wr_stb, ld_err, ld_en;
  logic [7:0]  io_wr_addr, io_wr_data, ld_data;
  logic [15:0] ld_addr;

  z80_bus_responder_if bus_if();

  z80_bus_responder #(
    .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .M1_WAIT(M1_WAIT),
    .IO_PAGE(IO_PAGE), .INTACK_VEC(INTACK_VEC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if),
    .busy(busy), .io_wr_stb(io_wr_stb), .io_wr_addr(io_wr_addr),
    .io_wr_data(io_wr_data), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model and scoreboard ----------------
  typedef struct { string name; logic [7:0] di; int waits; } txn_t;
  typedef struct { logic [7:0] port; logic [7:0] data; } iow_t;

  logic [7:0] ref_mem [0:65535];
  logic [7:0] ref_di = 8'hFF;
  txn_t       txn_q[$];
  iow_t       iow_q[$];
  int         lderr_exp = 0;
  int         rst_req = 0;
  int         timeouts = 0;
  bit         tb_done = 1'b0;

  function automatic int exp_waits(input int kind, input bit m1);
    int n;
    if (kind == K_MEM) n = MEM_WAIT + (m1 ? M1_WAIT : 0);
    else if (kind == K_IO) n = IO_WAIT;
    else n = 0;
`ifndef Z80_BUS_RESPONDER_WAIT_EN
    n = 0;
`endif
    return (n > 30) ? 30 : n;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_bus();
    bus_if.mreq_n = 1'b1; bus_if.iorq_n = 1'b1; bus_if.rd_n = 1'b1;
    bus_if.wr_n = 1'b1; bus_if.m1_n = 1'b1; bus_if.rfsh_n = 1'b1;
  endtask

  task automatic ld_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic refresh_cycle(input logic [15:0] a);
    @(negedge clk);
    bus_if.A = a; bus_if.mreq_n = 1'b0; bus_if.rfsh_n = 1'b0; bus_if.rd_n = 1'b0;
    repeat (3) @(negedge clk);
    idle_bus();
    @(posedge clk);
  endtask

  // One complete CPU bus cycle. ld_hit drives the load port at the same
  // address on the commit edge; rst_mid pulls reset right after detection.
  task automatic bus_txn(input int kind, input bit wr, input bit m1,
                         input logic [15:0] a, input logic [7:0] d,
                         input bit ld_hit, input logic [7:0] ld_val,
                         input bit rst_mid, input string nm);
    logic [15:0] ea;
    txn_t t;
    int n;
    ea = (kind == K_IO) ? {IO_PAGE, a[7:0]} : a;
    t.name = nm;
    if (rst_mid) begin
      ref_di  = 8'hFF;
      t.di    = 8'hFF;
      t.waits = -1;
    end else begin
      if (!wr) ref_di = (kind == K_INT) ? INTACK_VEC : ref_mem[ea];
      if (wr) begin
        ref_mem[ea] = d;
        if (kind == K_IO) iow_q.push_back('{port: a[7:0], data: d});
        if (ld_hit) lderr_exp++;
      end else if (ld_hit) begin
        ref_mem[ea] = ld_val;
      end
      t.di    = ref_di;
      t.waits = exp_waits(kind, m1);
    end
    txn_q.push_back(t);

    @(negedge clk);
    bus_if.A = a; bus_if.cpu_dout = d;
    bus_if.m1_n   = !((kind == K_MEM && m1) || kind == K_INT);
    bus_if.mreq_n = (kind != K_MEM);
    bus_if.iorq_n = (kind == K_MEM);
    bus_if.rd_n   = wr || (kind == K_INT);
    bus_if.wr_n   = !wr;
    @(posedge clk);
    @(negedge clk);
    if (rst_mid) begin
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_req++;
      @(negedge clk);
      reset_n = 1'b1;
      idle_bus();
    end else begin
      n = 0;
      while (!bus_if.wait_n && n < 64) begin
        @(negedge clk);
        n++;
      end
      if (n >= 64) timeouts++;
      if (ld_hit) begin
        ld_en = 1'b1; ld_addr = ea; ld_data = ld_val;
      end
      @(negedge clk);
      ld_en = 1'b0;
      idle_bus();
    end
    @(posedge clk);
  endtask

  initial begin
    logic [7:0]  his [5];
    logic [7:0]  los [10];
    logic [15:0] a;
    logic [7:0]  d, d2;
    int          sel;
    his = '{8'h00, 8'h10, 8'h20, 8'h30, 8'hFF};
    los = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h42, 8'hFF};
    idle_bus();
    bus_if.A = 16'h0000; bus_if.cpu_dout = 8'h00;
    ld_en = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_req++;
    @(negedge clk);
    reset_n = 1'b1;

    for (int h = 0; h < 5; h++)
      for (int l = 0; l < 10; l++)
        ld_write({his[h], los[l]}, 8'($urandom));
    ld_write(16'h0000, 8'hCB);
    ld_write(16'h0001, 8'h9B);
    ld_write(16'h3000, 8'h11);

    // Directed cases
    bus_txn(K_MEM, 0, 1, 16'h0000, 8'h00, 0, 8'h00, 0, "fetch_0000");
    bus_txn(K_MEM, 0, 1, 16'h0001, 8'h00, 0, 8'h00, 0, "fetch_0001");
    bus_txn(K_IO,  1, 0, 16'h5A42, 8'h5A, 0, 8'h00, 0, "out_42");
    bus_txn(K_MEM, 0, 0, 16'h1042, 8'h00, 0, 8'h00, 0, "mem_rd_1042");
    bus_txn(K_IO,  0, 0, 16'hC342, 8'h00, 0, 8'h00, 0, "in_42");
    refresh_cycle(16'h2000);
    bus_txn(K_INT, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, "intack");
    bus_txn(K_MEM, 1, 0, 16'h2000, 8'h77, 1, 8'h33, 0, "wr_collide_2000");
    bus_txn(K_MEM, 0, 0, 16'h2000, 8'h00, 0, 8'h00, 0, "mem_rd_2000");
    bus_txn(K_MEM, 0, 0, 16'h0005, 8'h00, 1, 8'hAA, 0, "rd_ld_same_0005");
    bus_txn(K_MEM, 0, 0, 16'h0005, 8'h00, 0, 8'h00, 0, "mem_rd_0005");
    bus_txn(K_MEM, 1, 0, 16'h3000, 8'h99, 0, 8'h00, 1, "rst_abort_3000");
    bus_txn(K_MEM, 0, 0, 16'h3000, 8'h00, 0, 8'h00, 0, "mem_rd_3000");
    bus_txn(K_MEM, 1, 0, 16'hFFFF, 8'hE1, 0, 8'h00, 0, "mem_wr_ffff");
    bus_txn(K_MEM, 0, 0, 16'hFFFF, 8'h00, 0, 8'h00, 0, "mem_rd_ffff");

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      a   = {his[$urandom_range(0, 4)], los[$urandom_range(0, 9)]};
      d   = 8'($urandom);
      d2  = 8'($urandom);
      case (sel)
        0: bus_txn(K_MEM, 0, 1, a, d, 0, d2, 0, "fetch");
        1: bus_txn(K_MEM, 0, 0, a, d, 0, d2, 0, "mem_rd");
        2: bus_txn(K_MEM, 1, 0, a, d, 0, d2, 0, "mem_wr");
        3: bus_txn(K_IO, 0, 0, {d2, a[7:0]}, d, 0, d2, 0, "io_rd");
        4: bus_txn(K_IO, 1, 0, {d2, a[7:0]}, d, 0, d2, 0, "io_wr");
        5: bus_txn(K_INT, 0, 0, a, d, 0, d2, 0, "intack");
        6: refresh_cycle(a);
        7: ld_write(a, d);
        8: bus_txn(K_MEM, 1, 0, a, d, 1, d2, 0, "wr_collide");
        default: bus_txn(($urandom_range(0, 1) == 0) ? K_MEM : K_IO, 0, 0, a, d, 1, d2, 0, "rd_ld_same");
      endcase
    end
    repeat (5) @(negedge clk);
    tb_done = 1'b1;
  end

  // ---------------- monitor ----------------
  int n_tests = 0;
  int n_fail = 0;
  int rst_done = 0;
  int lderr_seen = 0;
  int wcnt = 0;
  int cyc = 0;
  bit busy_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    txn_t t;
    iow_t w;
    cyc++;
    if (rst_req != rst_done) begin
      rst_done = rst_req;
      chk("rst_di", 32'(bus_if.di), 32'hFF);
      chk("rst_wait_n", 32'(bus_if.wait_n), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_io_wr_stb", 32'(io_wr_stb), 32'h0);
      chk("rst_io_wr_addr", 32'(io_wr_addr), 32'h0);
      chk("rst_io_wr_data", 32'(io_wr_data), 32'h0);
      chk("rst_ld_err", 32'(ld_err), 32'h0);
    end
    if (busy && !bus_if.wait_n) wcnt++;
    if (busy_prev && !busy) begin
      if (txn_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_txn: got di=%02h, expected no bus cycle", bus_if.di);
      end else begin
        t = txn_q.pop_front();
        chk({t.name, "_di"}, 32'(bus_if.di), 32'(t.di));
        if (t.waits >= 0) chk({t.name, "_waits"}, wcnt, t.waits);
        $display("[TB] %s di=%02h waits=%0d", t.name, bus_if.di, wcnt);
      end
      wcnt = 0;
    end
    busy_prev = busy;
    if (io_wr_stb) begin
      if (iow_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_io_wr_stb: got port=%02h, expected no pulse", io_wr_addr);
      end else begin
        w = iow_q.pop_front();
        chk("io_wr_addr", 32'(io_wr_addr), 32'(w.port));
        chk("io_wr_data", 32'(io_wr_data), 32'(w.data));
      end
    end
    if (ld_err) begin
      lderr_seen++;
      chk("ld_err_pending", 32'(lderr_seen <= lderr_exp), 32'h1);
    end
    if (tb_done || cyc > 60000) begin
      if (!tb_done) begin
        n_tests++; n_fail++;
        $display("FAIL watchdog: got %0d cycles, expected completion", cyc);
      end
      chk("txn_left", txn_q.size(), 0);
      chk("iow_left", iow_q.size(), 0);
      chk("ld_err_count", lderr_seen, lderr_exp);
      chk("timeouts", timeouts, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

endmodule
